// File: rtl/ixc_cap_loop_ctl.sv
// ixc_cap_loop_ctl: round-robin arbiter that hands the capture loop to one requester at a time.
// Define IXC_CAP_LOOP_CTL_TIMEOUT_EN to build the WAIT timeout counter and the sticky err flag.
module ixc_cap_loop_ctl #(
  parameter int NREQ  = 4,
  parameter int TMO_W = 8
) (
  input  logic             bClk,
  input  logic             bRst,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  done,
  output logic             capEn,
  input  logic             bcLatchEn,
  input  logic             bpHalt,
  input  logic [TMO_W-1:0] tmoCfg,
  output logic             busy,
  output logic             err,
  input  logic             errClr
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_LATCH   = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            cap_en_q, cap_en_d;
  logic            busy_q, busy_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic [IW:0]     pick_s;
  logic            own_req_s;
  logic            tmo_hit_s;
  logic            err_set_s;

  // Search starts at the pointer and wraps; bit IW of the result flags a hit.
  function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] r, input logic [IW-1:0] p);
    logic [IW:0] res;
    int          k;
    res = {(IW+1){1'b0}};
    for (int i = NREQ - 1; i >= 0; i--) begin
      k   = (int'(p) + i) % NREQ;
      res = r[k[IW-1:0]] ? {1'b1, k[IW-1:0]} : res;
    end
    return res;
  endfunction

  function automatic logic [IW-1:0] ptr_after(input logic [IW-1:0] idx);
    return (idx == IW'(NREQ - 1)) ? IW'(0) : idx + IW'(1);
  endfunction

  assign pick_s    = rr_pick(req, ptr_q);
  assign own_req_s = |(req & gnt_q);

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    done_d    = {NREQ{1'b0}};
    cap_en_d  = cap_en_q;
    ptr_d     = ptr_q;
    gidx_d    = gidx_q;
    err_set_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_s[IW]) begin
          state_d  = ST_WAIT;
          gidx_d   = pick_s[IW-1:0];
          gnt_d    = {{(NREQ-1){1'b0}}, 1'b1} << pick_s[IW-1:0];
          cap_en_d = 1'b1;
        end else begin
          gnt_d    = {NREQ{1'b0}};
          cap_en_d = 1'b0;
        end
      end
      // A dropped request outranks a latch, and a latch outranks a coincident timeout.
      ST_WAIT: begin
        if (!own_req_s) begin
          state_d  = ST_RELEASE;
          gnt_d    = {NREQ{1'b0}};
          cap_en_d = 1'b0;
        end else if (bcLatchEn) begin
          state_d  = ST_LATCH;
        end else if (tmo_hit_s) begin
          state_d   = ST_RELEASE;
          gnt_d     = {NREQ{1'b0}};
          cap_en_d  = 1'b0;
          err_set_s = 1'b1;
        end else begin
          state_d  = ST_WAIT;
        end
      end
      ST_LATCH: begin
        if (!own_req_s) begin
          state_d  = ST_RELEASE;
          gnt_d    = {NREQ{1'b0}};
          cap_en_d = 1'b0;
        end else if (!bpHalt) begin
          state_d  = ST_RELEASE;
          gnt_d    = {NREQ{1'b0}};
          cap_en_d = 1'b0;
          done_d   = gnt_q;
        end else begin
          state_d  = ST_LATCH;
        end
      end
      ST_RELEASE: begin
        state_d  = ST_IDLE;
        gnt_d    = {NREQ{1'b0}};
        cap_en_d = 1'b0;
        ptr_d    = ptr_after(gidx_q);
      end
      default: begin
        state_d  = ST_IDLE;
        gnt_d    = {NREQ{1'b0}};
        cap_en_d = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge bClk or posedge bRst) begin
    if (bRst) begin
      state_q  <= ST_IDLE;
      gnt_q    <= {NREQ{1'b0}};
      done_q   <= {NREQ{1'b0}};
      cap_en_q <= 1'b0;
      busy_q   <= 1'b0;
      ptr_q    <= {IW{1'b0}};
      gidx_q   <= {IW{1'b0}};
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      cap_en_q <= cap_en_d;
      busy_q   <= busy_d;
      ptr_q    <= ptr_d;
      gidx_q   <= gidx_d;
    end
  end

`ifdef IXC_CAP_LOOP_CTL_TIMEOUT_EN
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] cnt_inc_s;
  logic             err_q, err_d;

  // The counter holds (WAIT cycles - 1), so the hit fires on the tmoCfg-th WAIT cycle.
  assign cnt_inc_s = cnt_q + {{(TMO_W-1){1'b0}}, 1'b1};
  assign tmo_hit_s = (tmoCfg != {TMO_W{1'b0}}) && (cnt_inc_s == tmoCfg);

  always_comb begin
    cnt_d = (state_q == ST_WAIT) ? cnt_inc_s : {TMO_W{1'b0}};
    if (err_set_s) begin
      err_d = 1'b1;
    end else if (errClr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge bClk or posedge bRst) begin
    if (bRst) begin
      cnt_q <= {TMO_W{1'b0}};
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_cfg_s;

  assign tmo_hit_s    = 1'b0;
  assign unused_cfg_s = ^{tmoCfg, errClr, err_set_s};
  assign err          = 1'b0;
`endif

  assign gnt   = gnt_q;
  assign done  = done_q;
  assign capEn = cap_en_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_ixc_cap_loop_ctl.sv
// Scoreboard bench for ixc_cap_loop_ctl: a transaction-level model predicts each grant episode,
// a negedge monitor matches what the DUT shows against the predicted queue.
module tb_ixc_cap_loop_ctl;
  localparam int NREQ  = 4;
  localparam int TMO_W = 8;
`ifdef IXC_CAP_LOOP_CTL_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic             bClk;
  logic             bRst;
  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  gnt;
  logic [NREQ-1:0]  done;
  logic             capEn;
  logic             bcLatchEn;
  logic             bpHalt;
  logic [TMO_W-1:0] tmoCfg;
  logic             busy;
  logic             err;
  logic             errClr;

  ixc_cap_loop_ctl #(.NREQ(NREQ), .TMO_W(TMO_W)) dut (
    .bClk(bClk), .bRst(bRst), .req(req), .gnt(gnt), .done(done), .capEn(capEn),
    .bcLatchEn(bcLatchEn), .bpHalt(bpHalt), .tmoCfg(tmoCfg), .busy(busy),
    .err(err), .errClr(errClr)
  );

  initial bClk = 1'b0;
  always #5 bClk = ~bClk;

  typedef struct {
    int              idx;
    int              dur;
    logic [NREQ-1:0] done_exp;
    logic            err_grant;
    logic            err_rel;
  } exp_t;

  exp_t            exp_q[$];
  int              n_checks = 0;
  int              n_fail   = 0;
  int              m_ptr    = 0;
  logic            m_err    = 1'b0;
  logic            mon_en   = 1'b0;
  logic [NREQ-1:0] mon_pg;
  int              mon_run;
  logic            mon_idle;
  exp_t            mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One grant episode. l: WAIT cycle where bcLatchEn rises (0 = never); h: LATCH cycles with
  // bpHalt still high; a: cycle the granted req bit drops (0 = never); t: tmoCfg;
  // clr_sel: errClr cycle (-1 none, 0 in IDLE, >0 a WAIT cycle clamped to the WAIT exit).
  task automatic run_txn(input logic [NREQ-1:0] pat, input int l, input int h, input int a,
                         input int t, input int clr_sel);
    exp_t            e;
    int              idx, we, kind, le, rel, tt, clr_c, j;
    bit              found;
    logic [NREQ-1:0] tmp, bitv;
    idx = 0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      j   = (m_ptr + i) % NREQ;
      tmp = pat >> j;
      if (!found && tmp[0]) begin
        idx   = j;
        found = 1'b1;
      end
    end
    // kind: 0 abort, 1 normal completion, 2 timeout
    tt = TMO_EN ? t : 0;
    we = 1000;
    if (a != 0) we = a;
    if (l != 0 && l < we) we = l;
    if (tt != 0 && tt < we) we = tt;
    if (we == 1000) begin
      $display("FAIL stimulus: episode has no way to end");
      $fatal(1);
    end
    if (a != 0 && a == we) begin
      kind = 0;
      rel  = we + 1;
    end else if (l != 0 && l == we) begin
      le = l + h + 1;
      if (a != 0 && a <= le) begin
        kind = 0;
        rel  = a + 1;
      end else begin
        kind = 1;
        rel  = le + 1;
      end
    end else begin
      kind = 2;
      rel  = we + 1;
    end
    clr_c = (clr_sel > we) ? we : clr_sel;
    bitv  = 4'b0001 << idx;
    e.idx       = idx;
    e.dur       = rel - 1;
    e.done_exp  = (kind == 1) ? bitv : 4'b0000;
    e.err_grant = m_err && (clr_c != 0);
    e.err_rel   = (kind == 2) || (m_err && (clr_c < 0));
    exp_q.push_back(e);
    m_err = e.err_rel;
    m_ptr = (idx + 1) % NREQ;
    for (int c = 0; c <= rel; c++) begin
      req       = (a != 0 && c >= a) ? (pat & ~bitv) : pat;
      bcLatchEn = (l != 0 && c >= l && c < rel);
      bpHalt    = (c <= l + h);
      errClr    = (c == clr_c);
      tmoCfg    = 8'(t);
      @(posedge bClk);
      #1;
    end
  endtask

  // Monitor: sample mid-cycle, peek at each new grant, pop at each release.
  initial begin
    mon_pg   = 4'b0000;
    mon_run  = 0;
    mon_idle = 1'b0;
    forever begin
      @(negedge bClk);
      if (mon_en) begin
        check("gnt_onehot0", 32'($countones(gnt) <= 1), 32'd1);
        check("capen_vs_gnt", 32'(capEn), 32'(|gnt));
        if (mon_idle) begin
          check("idle_after_release", 32'(busy), 32'd0);
          mon_idle = 1'b0;
        end
        if (gnt != 4'b0000 && mon_pg == 4'b0000) begin
          mon_run = 1;
          check("pending_at_grant", 32'(exp_q.size()), 32'd1);
          check("done_quiet", 32'(done), 32'd0);
          if (exp_q.size() != 0) begin
            mon_e = exp_q[0];
            check("grant_vector", 32'(gnt), 32'(4'b0001 << mon_e.idx));
            check("err_at_grant", 32'(err), 32'(mon_e.err_grant));
            check("busy_at_grant", 32'(busy), 32'd1);
          end
        end else if (gnt != 4'b0000) begin
          mon_run++;
          check("done_quiet", 32'(done), 32'd0);
        end else if (mon_pg != 4'b0000) begin
          check("pending_at_release", 32'(exp_q.size()), 32'd1);
          if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("grant_cycles", 32'(mon_run), 32'(mon_e.dur));
            check("done_pulse", 32'(done), 32'(mon_e.done_exp));
            check("err_at_release", 32'(err), 32'(mon_e.err_rel));
            check("busy_in_release", 32'(busy), 32'd1);
          end
          mon_idle = 1'b1;
        end else begin
          check("done_quiet", 32'(done), 32'd0);
        end
        mon_pg = gnt;
      end
    end
  end

  initial begin
    logic [NREQ-1:0] pat;
    int              l, h, a, t, cs, sel;
    bRst      = 1'b0;
    req       = 4'b0000;
    bcLatchEn = 1'b0;
    bpHalt    = 1'b1;
    tmoCfg    = 8'd0;
    errClr    = 1'b0;
    #2 bRst = 1'b1;
    #2;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_capen", 32'(capEn), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    #18 bRst = 1'b0;
    @(posedge bClk);
    #1;
    mon_en = 1'b1;

    for (int n = 0; n < 5; n++) run_txn(4'b1111, 2, 1, 0, 0, -1);
    run_txn(4'b0001, 3, 1, 0, 0, -1);
`ifdef IXC_CAP_LOOP_CTL_TIMEOUT_EN
    run_txn(4'b0010, 0, 0, 0, 5, -1);
    run_txn(4'b0010, 2, 0, 0, 0, 0);
    run_txn(4'b0001, 0, 0, 0, 4, 4);
    run_txn(4'b1000, 2, 1, 0, 0, 2);
`endif
    run_txn(4'b0100, 3, 1, 0, 3, -1);
    run_txn(4'b0100, 2, 3, 4, 0, -1);
    run_txn(4'b0110, 5, 0, 2, 0, -1);

    for (int n = 0; n < 150; n++) begin
      pat = 4'($urandom_range(1, 15));
      l   = $urandom_range(0, 6);
      h   = $urandom_range(0, 3);
      a   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 9) : 0;
      t   = $urandom_range(0, 8);
      if (l == 0 && a == 0 && !(TMO_EN && t != 0)) l = $urandom_range(1, 6);
      sel = $urandom_range(0, 3);
      cs  = (sel == 0) ? 0 : ((sel == 1) ? $urandom_range(1, 8) : -1);
      run_txn(pat, l, h, a, t, cs);
    end

    req = 4'b0000;
    @(negedge bClk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    mon_en = 1'b0;

    // Reset in the middle of a LATCH episode.
    @(posedge bClk);
    #1;
    req = 4'b0001;
    @(posedge bClk);
    #1;
    bcLatchEn = 1'b1;
    bpHalt    = 1'b1;
    @(posedge bClk);
    #1;
    check("latch_capen", 32'(capEn), 32'd1);
    check("latch_gnt", 32'(gnt), 32'h1);
    #2 bRst = 1'b1;
    #1;
    check("midrst_gnt", 32'(gnt), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_capen", 32'(capEn), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    bcLatchEn = 1'b0;
    req       = 4'b1000;
    @(posedge bClk);
    #2 bRst = 1'b0;
    #1;
    check("no_grant_before_edge", 32'(gnt), 32'd0);
    @(posedge bClk);
    #1;
    check("post_rst_gnt", 32'(gnt), 32'h8);
    check("post_rst_capen", 32'(capEn), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ixc_cap_loop_ctl.md
IXC_CAP_LOOP_CTL -- requirements
Module: ixc_cap_loop_ctl

Interface
REQ-001 The block SHALL have parameter NREQ, default 4: number of capture requesters (2..8).
REQ-002 The block SHALL have parameter TMO_W, default 8: width of the wait-timeout counter and of tmoCfg.
REQ-003 The block SHALL have port bClk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port bRst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port req, input, NREQ bits: capture request, one bit per requester, level-sensitive.
REQ-006 The block SHALL have port gnt, output, NREQ bits: one-hot grant, or all zero.
REQ-007 The block SHALL have port done, output, NREQ bits: one-cycle completion pulse to the granted requester.
REQ-008 The block SHALL have port capEn, output, 1 bit: drives the capture-loop enable (asserts bpWait).
REQ-009 The block SHALL have port bcLatchEn, input, 1 bit: latch-enable returned by the capture loop.
REQ-010 The block SHALL have port bpHalt, input, 1 bit: halt status returned by the capture loop.
REQ-011 The block SHALL have port tmoCfg, input, TMO_W bits: WAIT timeout in cycles; 0 disables the timeout.
REQ-012 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 The block SHALL have port err, output, 1 bit: sticky timeout flag.
REQ-014 The block SHALL have port errClr, input, 1 bit: synchronous clear for err.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT, LATCH and RELEASE; all outputs SHALL be registered.
REQ-016 In IDLE with any req bit high, the block SHALL grant round-robin, starting the search at the bit after the last granted index; gnt and capEn SHALL rise one cycle after req is sampled; next state is WAIT.
REQ-017 In WAIT, capEn=1 and the wait counter SHALL increment each cycle; bcLatchEn=1 SHALL move the FSM to LATCH.
REQ-018 In WAIT, when tmoCfg≠0 and the counter reaches tmoCfg with bcLatchEn=0, the block SHALL go to RELEASE, set err, and suppress done.
REQ-019 If bcLatchEn and the timeout occur in the same cycle, the block SHALL treat it as a latch, with no err.
REQ-020 In LATCH, capEn SHALL stay 1 while bpHalt=1; bpHalt=0 SHALL move the FSM to RELEASE, including when bpHalt is already 0 on entry.
REQ-021 In RELEASE, the block SHALL drive capEn=0 and gnt=0, pulse done[granted] for exactly one cycle (normal completion only), advance the round-robin pointer, and go to IDLE.
REQ-022 If the granted req bit falls during WAIT or LATCH, the block SHALL go to RELEASE with no done pulse and no err.
REQ-023 errClr SHALL clear err; a timeout in the same cycle as errClr SHALL win, leaving err=1.
REQ-024 At most one gnt bit SHALL ever be high, and gnt SHALL be nonzero only in WAIT and LATCH.

Reset
REQ-025 On bRst, the block SHALL asynchronously force the following, including mid-operation: state=IDLE, gnt=0, done=0, capEn=0, busy=0, err=0, counter=0, pointer=0 (requester 0 searched first).
REQ-026 After bRst falls, the first grant SHALL occur no earlier than the first rising edge of bClk.

Configuration
REQ-027 With macro IXC_CAP_LOOP_CTL_TIMEOUT_EN defined, the wait counter and timeout SHALL be implemented per REQ-017/018/019/023.
REQ-028 Without IXC_CAP_LOOP_CTL_TIMEOUT_EN, the block SHALL have no counter: WAIT exits only on bcLatchEn or req drop, err is tied 0, and tmoCfg and errClr are ignored.

Verification
REQ-029 Normal completion: req=0001, bcLatchEn at cycle 3, bpHalt low at cycle 5 -> gnt=0001 and capEn=1 from cycle 1, done[0] pulses in the RELEASE cycle, busy=0 afterwards.
REQ-030 Fairness: req=1111 held -> grant order 0,1,2,3,0; no index granted twice before all others have been granted.
REQ-031 Timeout (macro on): tmoCfg=5, bcLatchEn never asserted -> RELEASE after 5 WAIT cycles, err=1, no done; errClr -> err=0.
REQ-032 Tie: tmoCfg=3 with bcLatchEn first high on the 3rd WAIT cycle -> LATCH, err=0.
REQ-033 Abort: req[2] dropped during LATCH -> capEn=0 and gnt=0 within 2 cycles, no done[2].
REQ-034 Reset mid-LATCH: bRst pulsed -> all outputs 0 immediately; after release, req=1000 gives gnt=1000 one cycle later.
